// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the ceil(log2) helper used to size the bit counter.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    localparam int SUB_WIDTH_DEFAULT = 8;

    function automatic int sub_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor cell: difference = a - b - cin, borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic difference,
    output logic borrow
);

    assign difference = a ^ b ^ cin;
    // Borrow when b exceeds a, or when a==b and a borrow is already pending.
    assign borrow     = (~a & b) | (~(a ^ b) & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), one bit per clock LSB first,
// recirculating the full_sub borrow through a flop.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CNT_W = sub_clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             fs_diff;
    logic             fs_borrow;

    full_sub u_full_sub (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .cin        (brw_q),
        .difference (fs_diff),
        .borrow     (fs_borrow)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    r_sh_d  = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                r_sh_d = {fs_diff, r_sh_q[WIDTH-1:1]};
                brw_d  = fs_borrow;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last bit: publish results straight from this cycle's cell outputs.
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    diff_d   = r_sh_d;
                    borrow_d = fs_borrow;
                    ovf_d    = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        done_d  = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed cases and a
// WIDTH=3 exhaustive back-to-back stream.
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] diff;
        logic        brw;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start3;
    logic [7:0] a8, b8, diff8;
    logic [2:0] a3, b3, diff3;
    logic       ready8, busy8, done8, borrow8, ovf8;
    logic       ready3, busy3, done3, borrow3, ovf3;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_done8 = 0;
    int   n_done3 = 0;
    int   last_done3 = -1;
    exp_t q8[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(borrow8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .ready(ready3), .busy(busy3), .done(done3), .diff(diff3),
        .borrow_out(borrow3), .overflow(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int av, input int bv, input int c);
        exp_t e;
        int   half, sa, sb, r;
        half  = 1 << (w - 1);
        e.diff = 32'((av - bv) & ((1 << w) - 1));
        e.brw  = (av < bv);
        sa     = (av >= half) ? av - 2 * half : av;
        sb     = (bv >= half) ? bv - 2 * half : bv;
        r      = sa - sb;
        e.ovf  = (r < -half) || (r > half - 1);
        e.cyc  = c;
        return e;
    endfunction

    // Accept monitor: push expectations at each accepting edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst && ready8 && start8) q8.push_back(model(8, int'(a8), int'(b8), cyc));
        if (!rst && ready3 && start3) q3.push_back(model(3, int'(a3), int'(b3), cyc));
    end

    // Completion monitor: pop and compare on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            n_done8++;
            if (q8.size() == 0) begin
                check("u8_spurious_done", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                check("u8_diff", {24'd0, diff8}, e.diff);
                check("u8_borrow", {31'd0, borrow8}, {31'd0, e.brw});
                check("u8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
                check("u8_latency", 32'(cyc - e.cyc), 32'd8);
            end
        end
        if (done3) begin
            n_done3++;
            if (last_done3 >= 0) check("u3_period", 32'(cyc - last_done3), 32'd5);
            last_done3 = cyc;
            if (q3.size() == 0) begin
                check("u3_spurious_done", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                check("u3_diff", {29'd0, diff3}, e.diff);
                check("u3_borrow", {31'd0, borrow3}, {31'd0, e.brw});
                check("u3_ovf", {31'd0, ovf3}, {31'd0, e.ovf});
                check("u3_latency", 32'(cyc - e.cyc), 32'd3);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done8(input int budget);
        int n0;
        n0 = n_done8;
        for (int i = 0; i < budget && n_done8 == n0; i++) nxt();
        if (n_done8 == n0) check("u8_timeout", 32'd0, 32'd1);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input logic eo, input string tag);
        for (int i = 0; i < 20 && !ready8; i++) nxt();
        a8 = av; b8 = bv; start8 = 1'b1;
        nxt();
        start8 = 1'b0;
        check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
        wait_done8(20);
        check({tag, "_diff"}, {24'd0, diff8}, {24'd0, ed});
        check({tag, "_borrow"}, {31'd0, borrow8}, {31'd0, eb});
        check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
    endtask

    initial begin
        int n0;
        int idx;
        rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a3 = 3'd0; b3 = 3'd0;
        nxt(); nxt();
        check("rst_ready", {31'd0, ready8}, 32'd1);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_diff", {24'd0, diff8}, 32'd0);
        check("rst_borrow", {31'd0, borrow8}, 32'd0);
        check("rst_ovf", {31'd0, ovf8}, 32'd0);
        rst = 1'b0;
        nxt();

        op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "t1");
        check("t1_ready_in_done", {31'd0, ready8}, 32'd0);
        nxt();
        check("t1_ready_after", {31'd0, ready8}, 32'd1);

        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "t2a");
        op8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "t2b");
        op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t3a");

        // Second request while busy must be ignored; operand changes too.
        for (int i = 0; i < 20 && !ready8; i++) nxt();
        n0 = n_done8;
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        nxt();
        start8 = 1'b0;
        nxt(); nxt();
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        nxt();
        a8 = 8'h44; b8 = 8'h99;
        nxt();
        start8 = 1'b0;
        wait_done8(20);
        check("t4_diff", {24'd0, diff8}, 32'h22);
        for (int i = 0; i < 12; i++) nxt();
        check("t4_one_done", 32'(n_done8 - n0), 32'd1);
        check("t4_queue_empty", 32'(q8.size()), 32'd0);

        op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "t3b");

        // Asynchronous reset in the middle of an operation.
        for (int i = 0; i < 20 && !ready8; i++) nxt();
        a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
        nxt();
        start8 = 1'b0;
        nxt(); nxt(); nxt();
        #2;
        rst = 1'b1;
        #1;
        check("t5_ready", {31'd0, ready8}, 32'd1);
        check("t5_busy", {31'd0, busy8}, 32'd0);
        check("t5_done", {31'd0, done8}, 32'd0);
        check("t5_diff", {24'd0, diff8}, 32'd0);
        check("t5_borrow", {31'd0, borrow8}, 32'd0);
        check("t5_ovf", {31'd0, ovf8}, 32'd0);
        q8.delete();
        nxt();
        rst = 1'b0;
        nxt();
        op8(8'h09, 8'h04, 8'h05, 1'b0, 1'b0, "t5_after");

        // WIDTH=3 exhaustive stream with start held high.
        idx = 0;
        start3 = 1'b1;
        for (int i = 0; i < 600 && idx <= 64; i++) begin
            if (ready3) begin
                if (idx < 64) begin
                    a3 = 3'(idx >> 3);
                    b3 = 3'(idx);
                end else begin
                    start3 = 1'b0;
                end
                idx++;
            end else begin
                a3 = 3'($urandom_range(0, 7));
                b3 = 3'($urandom_range(0, 7));
            end
            nxt();
        end
        start3 = 1'b0;
        for (int i = 0; i < 20 && n_done3 < 64; i++) nxt();
        check("u3_done_count", 32'(n_done3), 32'd64);
        check("u3_queue_empty", 32'(q3.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
